// File: rtl/ram_master_pkg.sv
// ram_master_pkg: shared widths and controller state encoding for ram_master_ctrl
// and the RAM instance it drives.
package ram_master_pkg;
    localparam int RM_ADDR_WIDTH = 8;
    localparam int RM_DATA_WIDTH = 10;
    localparam int RM_LEN_WIDTH  = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_READ    = 3'd2,
        S_DRAIN   = 3'd3,
        S_VFY_RD  = 3'd4,
        S_VFY_CAP = 3'd5
    } state_t;
endpackage

// File: rtl/ram_master_ctrl_if.sv
// ram_master_ctrl_if: request/response stream plus RAM pin bundle of ram_master_ctrl.
// master = controller side, slave = client and RAM side.
interface ram_master_ctrl_if
    import ram_master_pkg::*;
#(
    parameter int ADDR_WIDTH = RM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RM_DATA_WIDTH,
    parameter int LEN_WIDTH  = RM_LEN_WIDTH
) ();
    logic                  REQ_VALID;
    logic                  REQ_READY;
    logic                  REQ_WE;
    logic [ADDR_WIDTH-1:0] REQ_ADDR;
    logic [LEN_WIDTH-1:0]  REQ_LEN;
    logic [DATA_WIDTH-1:0] REQ_DATA;
    logic                  RSP_VALID;
    logic [DATA_WIDTH-1:0] RSP_DATA;
    logic                  RSP_LAST;
    logic                  MEM_EN;
    logic                  MEM_WE;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [DATA_WIDTH-1:0] MEM_DIN;
    logic [DATA_WIDTH-1:0] MEM_DOUT;
    logic                  ERR;

    modport master (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_LEN, REQ_DATA, MEM_DOUT,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_LAST,
               MEM_EN, MEM_WE, MEM_ADDR, MEM_DIN, ERR
    );

    modport slave (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_LEN, REQ_DATA, MEM_DOUT,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_LAST,
               MEM_EN, MEM_WE, MEM_ADDR, MEM_DIN, ERR
    );
endinterface

// File: rtl/burst_addr_cnt.sv
// burst_addr_cnt: loadable wrapping address incrementer with remaining-beat
// down-counter; o_last flags the final beat.
module burst_addr_cnt #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_rem;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr <= '0;
            r_rem  <= '0;
        end else if (i_load) begin
            r_addr <= i_addr;
            r_rem  <= i_len;
        end else if (i_step) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_rem == '0);
endmodule

// File: rtl/ram_master_ctrl.sv
// ram_master_ctrl: valid/ready front end that sequences a single-port synchronous RAM.
// Define RAM_MASTER_WR_VERIFY_EN to add read-back verification of every write (ERR).
module ram_master_ctrl
    import ram_master_pkg::*;
#(
    parameter int ADDR_WIDTH = RM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RM_DATA_WIDTH,
    parameter int LEN_WIDTH  = RM_LEN_WIDTH
) (
    input  logic              CLK,
    input  logic              RST,
    ram_master_ctrl_if.master bus
);
    state_t                r_state, w_next;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_mem_en, r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_din;
    logic                  r_tag_vld, r_tag_last, r_cap_vld, r_cap_last;
    logic                  r_rsp_valid, r_rsp_last;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  w_accept, w_step, w_last;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_accept = bus.REQ_VALID & r_ready;
    assign w_step   = (r_state == S_READ);

    burst_addr_cnt #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_cnt (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_load  (w_accept),
        .i_step  (w_step),
        .i_addr  (bus.REQ_ADDR),
        .i_len   (bus.REQ_LEN),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    always_comb begin
        w_next = S_IDLE;
        unique case (r_state)
            S_IDLE:   w_next = !w_accept ? S_IDLE : bus.REQ_WE ? S_WRITE : S_READ;
            S_READ:   w_next = w_last ? S_DRAIN : S_READ;
`ifdef RAM_MASTER_WR_VERIFY_EN
            S_WRITE:  w_next = S_VFY_RD;
            S_VFY_RD: w_next = S_VFY_CAP;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    // RAM pins follow the state one cycle later; read tags ride two stages behind
    // the address so capture lands in the cycle the RAM drives that word.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_wdata     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_tag_vld   <= 1'b0;
            r_tag_last  <= 1'b0;
            r_cap_vld   <= 1'b0;
            r_cap_last  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_next;
            r_ready     <= (w_next == S_IDLE);
            if (w_accept && bus.REQ_WE) r_wdata <= bus.REQ_DATA;
            r_mem_en    <= (r_state != S_IDLE);
            r_mem_we    <= (r_state == S_WRITE);
            if (r_state == S_WRITE || r_state == S_READ) r_mem_addr <= w_addr;
            if (r_state == S_WRITE) r_mem_din <= r_wdata;
            r_tag_vld   <= w_step;
            r_tag_last  <= w_step && w_last;
            r_cap_vld   <= r_tag_vld;
            r_cap_last  <= r_tag_last;
            r_rsp_valid <= r_cap_vld;
            r_rsp_last  <= r_cap_last;
            if (r_cap_vld) r_rsp_data <= bus.MEM_DOUT;
        end
    end

`ifdef RAM_MASTER_WR_VERIFY_EN
    logic r_vfy_tag, r_vfy_cap, r_err;

    // r_mem_din still holds the written word while its read-back is on the bus
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_vfy_tag <= 1'b0;
            r_vfy_cap <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_vfy_tag <= (r_state == S_VFY_RD);
            r_vfy_cap <= r_vfy_tag;
            if (r_vfy_cap && bus.MEM_DOUT != r_mem_din) r_err <= 1'b1;
        end
    end

    assign bus.ERR = r_err;
`else
    assign bus.ERR = 1'b0;
`endif

    assign bus.REQ_READY = r_ready;
    assign bus.RSP_VALID = r_rsp_valid;
    assign bus.RSP_DATA  = r_rsp_data;
    assign bus.RSP_LAST  = r_rsp_last;
    assign bus.MEM_EN    = r_mem_en;
    assign bus.MEM_WE    = r_mem_we;
    assign bus.MEM_ADDR  = r_mem_addr;
    assign bus.MEM_DIN   = r_mem_din;
endmodule

// File: tb/tb_ram_master_ctrl.sv
// tb_ram_master_ctrl: directed plus random requests against a RAM model; responses
// are checked against an array/queue reference of the RAM contents.
module tb_ram_master_ctrl;
    import ram_master_pkg::*;

`ifdef RAM_MASTER_WR_VERIFY_EN
    localparam int WR_BUSY = 3;
    localparam int EXP_ERR = 1;
`else
    localparam int WR_BUSY = 1;
    localparam int EXP_ERR = 0;
`endif

    typedef struct {
        logic [9:0] d;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ram_init = 1'b1;
    logic corrupt = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic prev_mid = 1'b0;
    time  acc_t = 0;
    time  acc_a = 0;
    logic [9:0] ref_mem [256];
    exp_t exp_q [$];

    ram_master_ctrl_if bus ();

    ram_master_ctrl dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] init_val(input int i);
        return 10'((i * 97 + 5) & 32'h3ff);
    endfunction

    // synchronous RAM: registered read port, bus released when not reading
    logic [9:0] ram [256];
    logic [9:0] ram_q = '0;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else if (bus.MEM_EN && bus.MEM_WE) begin
            ram[bus.MEM_ADDR] <= bus.MEM_DIN ^ {9'b0, corrupt};
        end
        if (bus.MEM_EN && !bus.MEM_WE) ram_q <= ram[bus.MEM_ADDR];
    end
    assign bus.MEM_DOUT = (bus.MEM_EN && !bus.MEM_WE) ? ram_q : 'z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.RSP_VALID) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 32'(exp_q.size()), 1);
            else begin
                chk("rsp_data", 32'(bus.RSP_DATA), 32'(exp_q[0].d));
                chk("rsp_last", 32'(bus.RSP_LAST), 32'(exp_q[0].last));
                void'(exp_q.pop_front());
            end
        end
        if (prev_mid) chk("rsp_gap", 32'(bus.RSP_VALID), 1);
        prev_mid <= rst_n && bus.RSP_VALID && !bus.RSP_LAST;
    end

    // called just after a negedge; returns at the negedge after the acceptance edge
    task automatic send(input logic we, input logic [7:0] a, input logic [3:0] l, input logic [9:0] d);
        int n = 0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_WE    = we;
        bus.REQ_ADDR  = a;
        bus.REQ_LEN   = l;
        bus.REQ_DATA  = d;
        while (!bus.REQ_READY && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk("req_accept", 32'(bus.REQ_READY), 1);
        @(posedge clk);
        acc_t = $time;
        if (we) ref_mem[a] = d ^ {9'b0, corrupt};
        else for (int i = 0; i <= int'(l); i++) exp_q.push_back('{ref_mem[8'(int'(a) + i)], i == int'(l)});
        @(negedge clk);
        bus.REQ_VALID = 1'b0;
    endtask

    task automatic busy_check();
        int n = 0;
        while (!bus.REQ_READY && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("wr_busy", 32'(n), 32'(WR_BUSY));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("drain", 32'(exp_q.size()), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_WE    = 1'b0;
        bus.REQ_ADDR  = '0;
        bus.REQ_LEN   = '0;
        bus.REQ_DATA  = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.REQ_READY), 1);
        chk("rst_rsp_valid", 32'(bus.RSP_VALID), 0);
        chk("rst_mem_en", 32'(bus.MEM_EN), 0);
        chk("rst_mem_addr", 32'(bus.MEM_ADDR), 0);
        chk("rst_err", 32'(bus.ERR), 0);
        ram_init = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        send(1'b1, 8'h10, 4'd0, 10'h155);
        busy_check();
        send(1'b0, 8'h10, 4'd0, 10'h0);
        for (int k = 1; k <= 3; k++) begin
            chk("lat_early", 32'(bus.RSP_VALID), 0);
            @(negedge clk);
        end
        chk("lat_valid", 32'(bus.RSP_VALID), 1);
        chk("lat_data", 32'(bus.RSP_DATA), 32'h155);
        chk("lat_last", 32'(bus.RSP_LAST), 1);
        drain();

        for (int i = 0; i < 4; i++) send(1'b1, 8'(8'h20 + i), 4'd0, 10'(i + 1));
        send(1'b0, 8'h20, 4'd3, 10'h0);
        drain();

        send(1'b1, 8'hFE, 4'd0, 10'd7);
        send(1'b1, 8'hFF, 4'd0, 10'd8);
        send(1'b1, 8'h00, 4'd0, 10'd9);
        send(1'b0, 8'hFE, 4'd2, 10'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wrap_addr", 32'(bus.MEM_ADDR), 32'((8'hFE + k) & 8'hFF));
            chk("wrap_rd", 32'({bus.MEM_EN, bus.MEM_WE}), 32'b10);
        end
        drain();

        send(1'b0, 8'h30, 4'd2, 10'h0);
        acc_a = acc_t;
        send(1'b0, 8'h7C, 4'd1, 10'h0);
        chk("b2b_accept", 32'((acc_t - acc_a) / 10), 5);
        drain();

        for (int i = 0; i < 40; i++)
            send(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom), 10'($urandom));
        drain();

        send(1'b0, 8'h40, 4'd7, 10'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk("mrst_rsp", 32'({bus.RSP_VALID, bus.RSP_LAST}), 0);
        chk("mrst_rsp_data", 32'(bus.RSP_DATA), 0);
        chk("mrst_mem", 32'({bus.MEM_EN, bus.MEM_WE}), 0);
        chk("mrst_mem_addr", 32'(bus.MEM_ADDR), 0);
        chk("mrst_mem_din", 32'(bus.MEM_DIN), 0);
        chk("mrst_err", 32'(bus.ERR), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_ready", 32'(bus.REQ_READY), 1);
        repeat (20) @(negedge clk);

        send(1'b1, 8'h51, 4'd0, 10'h0F0);
        busy_check();
        repeat (3) @(negedge clk);
        chk("err_clean", 32'(bus.ERR), 0);
        corrupt = 1'b1;
        send(1'b1, 8'h50, 4'd0, 10'h2AA);
        busy_check();
        repeat (4) @(negedge clk);
        corrupt = 1'b0;
        chk("err_set", 32'(bus.ERR), 32'(EXP_ERR));
        send(1'b1, 8'h52, 4'd0, 10'h011);
        busy_check();
        repeat (5) @(negedge clk);
        chk("err_sticky", 32'(bus.ERR), 32'(EXP_ERR));
        send(1'b0, 8'h50, 4'd2, 10'h0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
